// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: splits 64-bit stores (and 64-bit loads under LOAD64_EN) into two
// 32-bit data-memory beats, stalling upstream for the first beat. All state changes on falling Clk.
module mem_stage_ctrl (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemWrite64,
  input  logic        MemRead64,
  input  logic [31:0] Adrs_MEM,
  input  logic [31:0] Rt_data_MEM,
  input  logic [63:0] Rt_data64_MEM,
  input  logic [4:0]  RegWr_MEM,
  input  logic [9:0]  WB_control_MEM,
  input  logic [31:0] dm_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  output logic        dm_re,
  output logic        Stall_MEM,
  output logic [31:0] Mem_data_WB,
  output logic [63:0] Mem_data64_WB,
  output logic [31:0] Alu_out_WB,
  output logic [4:0]  RegWr_WB,
  output logic [9:0]  WB_control_WB
);

  typedef enum logic [1:0] {IDLE, ST64_HI, LD64_HI} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] w_adrs_hi;
  logic        w_bubble;
  logic        w_rd_done;
  logic [31:0] r_mem_data;
  logic [31:0] r_alu_out;
  logic [4:0]  r_regwr;
  logic [9:0]  r_wb_ctl;

  assign w_adrs_hi = Adrs_MEM + 32'd4;

  always_comb begin
    w_state_nxt = r_state;
    dm_addr     = Adrs_MEM;
    dm_wdata    = Rt_data_MEM;
    dm_we       = 1'b0;
    dm_re       = 1'b0;
    Stall_MEM   = 1'b0;
    w_bubble    = 1'b0;
    w_rd_done   = 1'b0;
    if (!Rst) begin
      case (r_state)
        IDLE: begin
          if (MemWrite64) begin
            dm_wdata    = Rt_data64_MEM[31:0];
            dm_we       = 1'b1;
            Stall_MEM   = 1'b1;
            w_bubble    = 1'b1;
            w_state_nxt = ST64_HI;
          end
`ifdef LOAD64_EN
          else if (MemRead64) begin
            dm_re       = 1'b1;
            Stall_MEM   = 1'b1;
            w_bubble    = 1'b1;
            w_state_nxt = LD64_HI;
          end
`endif
          else if (MemWrite) begin
            dm_we = 1'b1;
          end else if (MemRead) begin
            dm_re     = 1'b1;
            w_rd_done = 1'b1;
          end
        end
        ST64_HI: begin
          dm_addr     = w_adrs_hi;
          dm_wdata    = Rt_data64_MEM[63:32];
          dm_we       = 1'b1;
          w_state_nxt = IDLE;
        end
        LD64_HI: begin
          dm_addr     = w_adrs_hi;
          dm_re       = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // First beat of a split op writes a bubble; data outputs keep their previous values.
  always_ff @(negedge Clk) begin
    if (Rst) begin
      r_state    <= IDLE;
      r_mem_data <= '0;
      r_alu_out  <= '0;
      r_regwr    <= '0;
      r_wb_ctl   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_bubble) begin
        r_regwr  <= '0;
        r_wb_ctl <= '0;
      end else begin
        r_alu_out <= Adrs_MEM;
        r_regwr   <= RegWr_MEM;
        r_wb_ctl  <= WB_control_MEM;
      end
      if (w_rd_done) r_mem_data <= dm_rdata;
    end
  end

`ifdef LOAD64_EN
  logic [31:0] r_lo;
  logic [63:0] r_data64;

  always_ff @(negedge Clk) begin
    if (Rst) begin
      r_lo     <= '0;
      r_data64 <= '0;
    end else begin
      if (r_state == IDLE && dm_re && Stall_MEM) r_lo <= dm_rdata;
      if (r_state == LD64_HI) r_data64 <= {dm_rdata, r_lo};
    end
  end

  assign Mem_data64_WB = r_data64;
`else
  logic w_unused_rd64;
  assign w_unused_rd64 = MemRead64;
  assign Mem_data64_WB = '0;
`endif

  assign Mem_data_WB   = r_mem_data;
  assign Alu_out_WB    = r_alu_out;
  assign RegWr_WB      = r_regwr;
  assign WB_control_WB = r_wb_ctl;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a small behavioural data memory.
// Checks follow LOAD64_EN when the macro is defined for the build.
module tb_mem_stage_ctrl;

  logic        Clk = 1'b1;
  logic        Rst;
  logic        MemRead, MemWrite, MemWrite64, MemRead64;
  logic [31:0] Adrs_MEM, Rt_data_MEM;
  logic [63:0] Rt_data64_MEM;
  logic [4:0]  RegWr_MEM;
  logic [9:0]  WB_control_MEM;
  logic [31:0] dm_rdata, dm_addr, dm_wdata;
  logic        dm_we, dm_re, Stall_MEM;
  logic [31:0] Mem_data_WB, Alu_out_WB;
  logic [63:0] Mem_data64_WB;
  logic [4:0]  RegWr_WB;
  logic [9:0]  WB_control_WB;

  logic [31:0] mem [0:63];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mem_stage_ctrl dut (
    .Clk(Clk), .Rst(Rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemWrite64(MemWrite64), .MemRead64(MemRead64), .Adrs_MEM(Adrs_MEM),
    .Rt_data_MEM(Rt_data_MEM), .Rt_data64_MEM(Rt_data64_MEM),
    .RegWr_MEM(RegWr_MEM), .WB_control_MEM(WB_control_MEM), .dm_rdata(dm_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re),
    .Stall_MEM(Stall_MEM), .Mem_data_WB(Mem_data_WB), .Mem_data64_WB(Mem_data64_WB),
    .Alu_out_WB(Alu_out_WB), .RegWr_WB(RegWr_WB), .WB_control_WB(WB_control_WB)
  );

  always #5 Clk = ~Clk;

  assign dm_rdata = mem[dm_addr[7:2]];
  always @(negedge Clk) if (dm_we) mem[dm_addr[7:2]] <= dm_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic wr64, input logic rd64, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] d, input logic [63:0] d64,
                       input logic [4:0] rg, input logic [9:0] ct);
    MemWrite64 = wr64; MemRead64 = rd64; MemWrite = wr; MemRead = rd;
    Adrs_MEM = a; Rt_data_MEM = d; Rt_data64_MEM = d64;
    RegWr_MEM = rg; WB_control_MEM = ct;
    #1;
  endtask

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[16] = 32'h0000000A;
    mem[17] = 32'h0000000B;

    // Reset overrides a pending write
    Rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1, 64'h0, 5'd1, 10'h3FF);
    check("rst_we", dm_we, 1'b0);
    check("rst_stall", Stall_MEM, 1'b0);
    step();
    check("rst_alu", Alu_out_WB, 32'h0);
    check("rst_ctl", WB_control_WB, 10'h0);
    check("rst_rd", Mem_data_WB, 32'h0);
    check("rst_m64", Mem_data64_WB, 64'h0);
    Rst = 1'b0;

    // Single 32-bit store
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 64'h0, 5'd5, 10'h155);
    check("st_we", dm_we, 1'b1);
    check("st_addr", dm_addr, 32'h10);
    check("st_wdata", dm_wdata, 32'hDEADBEEF);
    check("st_stall", Stall_MEM, 1'b0);
    step();
    check("st_alu", Alu_out_WB, 32'h10);
    check("st_regwr", RegWr_WB, 5'd5);
    check("st_ctl", WB_control_WB, 10'h155);
    check("st_mem", mem[4], 32'hDEADBEEF);

    // Single 32-bit load
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 64'h0, 5'd6, 10'h011);
    check("ld_re", dm_re, 1'b1);
    check("ld_we", dm_we, 1'b0);
    step();
    check("ld_data", Mem_data_WB, 32'hDEADBEEF);

    // 64-bit store: stalled low beat, bubble, then high beat
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 64'h11112222_33334444, 5'd7, 10'h2AA);
    check("s64a_addr", dm_addr, 32'h20);
    check("s64a_wdata", dm_wdata, 32'h33334444);
    check("s64a_stall", Stall_MEM, 1'b1);
    check("s64a_we", dm_we, 1'b1);
    step();
    check("s64b_ctl", WB_control_WB, 10'h0);
    check("s64b_regwr", RegWr_WB, 5'd0);
    check("s64b_alu", Alu_out_WB, 32'h10);
    check("s64b_addr", dm_addr, 32'h24);
    check("s64b_wdata", dm_wdata, 32'h11112222);
    check("s64b_stall", Stall_MEM, 1'b0);
    check("s64b_we", dm_we, 1'b1);
    step();
    check("s64c_ctl", WB_control_WB, 10'h2AA);
    check("s64c_regwr", RegWr_WB, 5'd7);
    check("s64c_alu", Alu_out_WB, 32'h20);
    check("s64c_lo", mem[8], 32'h33334444);
    check("s64c_hi", mem[9], 32'h11112222);

    // Back-to-back 64-bit store at the top of the address space
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 64'hCAFEF00D_12345678, 5'd8, 10'h0AA);
    check("wrap_stall", Stall_MEM, 1'b1);
    check("wrap_addr_lo", dm_addr, 32'hFFFFFFFC);
    step();
    check("wrap_addr_hi", dm_addr, 32'h00000000);
    check("wrap_wdata_hi", dm_wdata, 32'hCAFEF00D);
    step();
    check("wrap_mem_lo", mem[63], 32'h12345678);
    check("wrap_mem_hi", mem[0], 32'hCAFEF00D);

    // Write wins over read
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h30, 32'h5A5A5A5A, 64'h0, 5'd2, 10'h002);
    check("prio_we", dm_we, 1'b1);
    check("prio_re", dm_re, 1'b0);
    step();
    check("prio_hold", Mem_data_WB, 32'hDEADBEEF);
    check("prio_mem", mem[12], 32'h5A5A5A5A);

    // Idle pass-through
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'h0, 64'h0, 5'd9, 10'h001);
    check("idle_we", dm_we, 1'b0);
    check("idle_re", dm_re, 1'b0);
    check("idle_addr", dm_addr, 32'h12345678);
    step();
    check("idle_alu", Alu_out_WB, 32'h12345678);
    check("idle_regwr", RegWr_WB, 5'd9);
    check("idle_ctl", WB_control_WB, 10'h001);

    // 64-bit load
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 64'h0, 5'd3, 10'h0F0);
`ifdef LOAD64_EN
    check("l64a_stall", Stall_MEM, 1'b1);
    check("l64a_re", dm_re, 1'b1);
    check("l64a_addr", dm_addr, 32'h40);
    step();
    check("l64b_ctl", WB_control_WB, 10'h0);
    check("l64b_addr", dm_addr, 32'h44);
    check("l64b_stall", Stall_MEM, 1'b0);
    check("l64b_re", dm_re, 1'b1);
    step();
    check("l64c_data", Mem_data64_WB, 64'h0000000B_0000000A);
    check("l64c_ctl", WB_control_WB, 10'h0F0);
`else
    check("l64_stall", Stall_MEM, 1'b0);
    check("l64_re", dm_re, 1'b0);
    check("l64_we", dm_we, 1'b0);
    step();
    check("l64_data", Mem_data64_WB, 64'h0);
    check("l64_hold", Mem_data_WB, 32'hDEADBEEF);
    check("l64_ctl", WB_control_WB, 10'h0F0);
`endif

    // Reset during the second store beat drops it
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h50, 32'h0, 64'h99999999_77777777, 5'd31, 10'h3FF);
    step();
    Rst = 1'b1;
    #1;
    check("rst64_we", dm_we, 1'b0);
    check("rst64_stall", Stall_MEM, 1'b0);
    step();
    check("rst64_alu", Alu_out_WB, 32'h0);
    check("rst64_regwr", RegWr_WB, 5'd0);
    check("rst64_ctl", WB_control_WB, 10'h0);
    check("rst64_rd", Mem_data_WB, 32'h0);
    Rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h60, 32'h0, 64'h0, 5'd0, 10'h0);
    check("rst64_idle_we", dm_we, 1'b0);
    check("rst64_idle_addr", dm_addr, 32'h60);
    check("rst64_mem_hi", mem[21], 32'h0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Clk  in  1  sole clock; all state updates on falling edge of Clk.
REQ-002 Rst  in  1  synchronous, active-high reset, sampled on falling edge of Clk.
REQ-003 MemRead  in  1  32-bit load request.
REQ-004 MemWrite  in  1  32-bit store request.
REQ-005 MemWrite64  in  1  64-bit store request.
REQ-006 MemRead64  in  1  64-bit load request; used only with LOAD64_EN.
REQ-007 Adrs_MEM  in  32  byte address, word aligned (bits [1:0] ignored).
REQ-008 Rt_data_MEM  in  32  32-bit store data.
REQ-009 Rt_data64_MEM  in  64  64-bit store data.
REQ-010 RegWr_MEM  in  5  destination register.
REQ-011 WB_control_MEM  in  10  write-back control bundle.
REQ-012 dm_rdata  in  32  data-memory read data, combinational from dm_addr.
REQ-013 dm_addr  out  32  data-memory word address (combinational).
REQ-014 dm_wdata  out  32  data-memory write data (combinational).
REQ-015 dm_we  out  1  data-memory write strobe (combinational).
REQ-016 dm_re  out  1  data-memory read strobe (combinational).
REQ-017 Stall_MEM  out  1  upstream hold; upstream registers do not advance on the next edge while high.
REQ-018 Mem_data_WB  out  32  registered 32-bit load result.
REQ-019 Mem_data64_WB  out  64  registered 64-bit load result.
REQ-020 Alu_out_WB  out  32  registered Adrs_MEM pass-through.
REQ-021 RegWr_WB  out  5  registered destination register.
REQ-022 WB_control_WB  out  10  registered control bundle.

Function
REQ-023 FSM states: IDLE, ST64_HI, LD64_HI. Encoding is free.
REQ-024 Request priority in IDLE: MemWrite64 > MemRead64 > MemWrite > MemRead. Lower-priority requests are suppressed.
REQ-025 IDLE with a single-beat op: one access at Adrs_MEM (dm_we with dm_wdata=Rt_data_MEM, or dm_re). Stall_MEM=0. WB outputs load on the next edge; latency 1 edge.
REQ-026 IDLE with MemWrite64: dm_addr=Adrs_MEM, dm_wdata=Rt_data64_MEM[31:0], dm_we=1, Stall_MEM=1. Next state ST64_HI. That edge loads a bubble (WB_control_WB=0, RegWr_WB=0; data outputs hold).
REQ-027 ST64_HI: dm_addr=Adrs_MEM+4, dm_wdata=Rt_data64_MEM[63:32], dm_we=1, Stall_MEM=0. WB outputs load from inputs. Next state IDLE; total latency 2 edges.
REQ-028 Adrs_MEM+4 is modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-029 No request in IDLE: dm_we=dm_re=0, dm_addr=Adrs_MEM, and the WB outputs still load from inputs (pass-through).
REQ-030 Back-to-back 64-bit ops: after ST64_HI returns to IDLE, a new MemWrite64 is accepted in the immediately following cycle.
REQ-031 Mem_data_WB loads dm_rdata only on an edge completing a read; otherwise it holds.

Reset
REQ-032 Rst=1: state becomes IDLE, an in-flight second beat is dropped, and all WB outputs clear to 0. Combinational strobes are 0 and Stall_MEM is 0 while Rst=1.
REQ-033 Rst has priority over every request on the same edge.

Configuration
REQ-034 Macro LOAD64_EN defined: MemRead64 in IDLE reads Adrs_MEM with Stall_MEM=1 and captures the low word, then enters LD64_HI. LD64_HI reads Adrs_MEM+4, Stall_MEM=0, and Mem_data64_WB={hi,lo} on exit.
REQ-035 LOAD64_EN undefined: MemRead64 is ignored, LD64_HI is unreachable, and Mem_data64_WB is constant 0.

Verification
REQ-036 MemWrite=1, Adrs=0x10, Rt_data=0xDEADBEEF -> one dm_we cycle at 0x10 and Stall_MEM=0; WB outputs updated after 1 edge.
REQ-037 MemWrite64=1, Adrs=0x20, Rt64=0x11112222_33334444 -> 0x33334444@0x20 with Stall_MEM=1, bubble, then 0x11112222@0x24; WB_control_WB valid after edge 2.
REQ-038 MemWrite64 at Adrs=0xFFFFFFFC -> second beat at 0x00000000.
REQ-039 MemWrite and MemRead both 1 -> write only; dm_re=0.
REQ-040 Rst asserted in ST64_HI -> no second dm_we, state IDLE, WB outputs 0, Stall_MEM=0.
REQ-041 LOAD64_EN, mem[0x40]=0xA, mem[0x44]=0xB, MemRead64 -> Mem_data64_WB=0x0000000B_0000000A after 2 edges; without the macro -> 0.
